// File: rtl/ifft_butterfly_16_1_pkg.sv
// Shared IFFT definitions: default widths and the round/shift/saturate helper
// used by every butterfly stage of the IFFT path.
package ifft_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int TW_W_DEF   = 16;
  localparam int CALC_W     = 64;

  // Result of a round/shift/saturate step: clamped value plus a clamp flag.
  typedef struct packed {
    logic signed [CALC_W-1:0] val;
    logic                     sat;
  } rss_t;

  // Round half toward +inf, arithmetic shift right, then clamp to out_w bits.
  function automatic rss_t round_shift_sat(input logic signed [CALC_W-1:0] value,
                                           input int shift,
                                           input int out_w);
    rss_t res;
    logic signed [CALC_W-1:0] one;
    logic signed [CALC_W-1:0] t;
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    one = 1;
    t   = value;
    if (shift > 0) t = t + (one <<< (shift - 1));
    t     = t >>> shift;
    max_v = (one <<< (out_w - 1)) - one;
    min_v = -(one <<< (out_w - 1));
    res.val = t;
    res.sat = 1'b0;
    if (t > max_v) begin
      res.val = max_v;
      res.sat = 1'b1;
    end else if (t < min_v) begin
      res.val = min_v;
      res.sat = 1'b1;
    end
    return res;
  endfunction

endpackage

// File: rtl/ifft_butterfly_16_1_cmul_conj_pipe.sv
// Two-stage difference * conj(w) pipe: S2 registers the four partial
// products, S3 combines them, rounds, saturates and registers x2.
module cmul_conj_pipe
  import ifft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF,
  parameter int SCALE  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic signed [DATA_W:0]   dr,
  input  logic signed [DATA_W:0]   di,
  input  logic signed [TW_W-1:0]   wr,
  input  logic signed [TW_W-1:0]   wi,
  output logic signed [DATA_W-1:0] x2r,
  output logic signed [DATA_W-1:0] x2i,
  output logic                     sat
);

  localparam int PW  = DATA_W + TW_W + 1;
  localparam int PRW = PW + 1;

  logic signed [PW-1:0]  p_rr, p_ii, p_ir, p_ri;
  logic signed [PRW-1:0] pr, pi;
  rss_t                  pr_rs, pi_rs;
  logic                  unused_hi;

  // S2: partial products; wi is only ever multiplied, never negated, so -1.0 is safe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      p_rr <= '0;
      p_ii <= '0;
      p_ir <= '0;
      p_ri <= '0;
    end else if (en) begin
      p_rr <= PW'(dr) * PW'(wr);
      p_ii <= PW'(di) * PW'(wi);
      p_ir <= PW'(di) * PW'(wr);
      p_ri <= PW'(dr) * PW'(wi);
    end
  end

  // S3 combine: conj(w) turns the usual cross terms into (rr + ii) and (ir - ri).
  always_comb begin
    pr        = PRW'(p_rr) + PRW'(p_ii);
    pi        = PRW'(p_ir) - PRW'(p_ri);
    pr_rs     = round_shift_sat(CALC_W'(pr), TW_W - 1 + SCALE, DATA_W);
    pi_rs     = round_shift_sat(CALC_W'(pi), TW_W - 1 + SCALE, DATA_W);
    sat       = pr_rs.sat | pi_rs.sat;
    unused_hi = ^{pr_rs.val[CALC_W-1:DATA_W], pi_rs.val[CALC_W-1:DATA_W]};
  end

  // S3 register: rounded, saturated twiddled difference.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x2r <= '0;
      x2i <= '0;
    end else if (en) begin
      x2r <= pr_rs.val[DATA_W-1:0];
      x2i <= pi_rs.val[DATA_W-1:0];
    end
  end

endmodule

// File: rtl/ifft_butterfly_16_1.sv
// Pipelined radix-2 inverse butterfly: x1 = (a+b)>>S, x2 = ((a-b)*conj(w))>>S.
// Three register stages share one enable so a stalled output freezes everything.
module ifft_butterfly_16_1
  import ifft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TW_W   = TW_W_DEF,
  parameter int SCALE  = 1
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic signed [DATA_W-1:0] ar,
  input  logic signed [DATA_W-1:0] ai,
  input  logic signed [DATA_W-1:0] br,
  input  logic signed [DATA_W-1:0] bi,
  input  logic signed [TW_W-1:0]   wr,
  input  logic signed [TW_W-1:0]   wi,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DATA_W-1:0] x1r,
  output logic signed [DATA_W-1:0] x1i,
  output logic signed [DATA_W-1:0] x2r,
  output logic signed [DATA_W-1:0] x2i,
  output logic                     ovf,
  input  logic                     ovf_clr
);

  localparam int SW = DATA_W + 1;

  logic                   adv;
  logic                   v1, v2, v3;
  logic signed [SW-1:0]   sr1, si1, dr1, di1;
  logic signed [SW-1:0]   sr2, si2;
  logic signed [TW_W-1:0] wr1, wi1;
  rss_t                   x1r_rs, x1i_rs;
  logic                   x1_sat, x2_sat;
  logic                   unused_hi;

  assign adv       = !v3 || out_ready;
  assign in_ready  = adv;
  assign out_valid = v3;

  // S1: widened sum/difference plus the twiddle, aligned for the product stage.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1  <= 1'b0;
      sr1 <= '0;
      si1 <= '0;
      dr1 <= '0;
      di1 <= '0;
      wr1 <= '0;
      wi1 <= '0;
    end else if (adv) begin
      v1  <= in_valid;
      sr1 <= SW'(ar) + SW'(br);
      si1 <= SW'(ai) + SW'(bi);
      dr1 <= SW'(ar) - SW'(br);
      di1 <= SW'(ai) - SW'(bi);
      wr1 <= wr;
      wi1 <= wi;
    end
  end

  // S2: delay the sum path to line up with the product registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v2  <= 1'b0;
      sr2 <= '0;
      si2 <= '0;
    end else if (adv) begin
      v2  <= v1;
      sr2 <= sr1;
      si2 <= si1;
    end
  end

  cmul_conj_pipe #(
    .DATA_W (DATA_W),
    .TW_W   (TW_W),
    .SCALE  (SCALE)
  ) u_cmul (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (adv),
    .dr    (dr1),
    .di    (di1),
    .wr    (wr1),
    .wi    (wi1),
    .x2r   (x2r),
    .x2i   (x2i),
    .sat   (x2_sat)
  );

  // Round and clamp the scaled sum ahead of the S3 register.
  always_comb begin
    x1r_rs    = round_shift_sat(CALC_W'(sr2), SCALE, DATA_W);
    x1i_rs    = round_shift_sat(CALC_W'(si2), SCALE, DATA_W);
    x1_sat    = x1r_rs.sat | x1i_rs.sat;
    unused_hi = ^{x1r_rs.val[CALC_W-1:DATA_W], x1i_rs.val[CALC_W-1:DATA_W]};
  end

  // S3: output valid and scaled sum register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v3  <= 1'b0;
      x1r <= '0;
      x1i <= '0;
    end else if (adv) begin
      v3  <= v2;
      x1r <= x1r_rs.val[DATA_W-1:0];
      x1i <= x1i_rs.val[DATA_W-1:0];
    end
  end

  // Sticky overflow: only real pairs (not bubbles) can set it; clear wins.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ovf <= 1'b0;
    end else if (ovf_clr) begin
      ovf <= 1'b0;
    end else if (adv && v2 && (x1_sat || x2_sat)) begin
      ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_ifft_butterfly_16_1.sv
// Scoreboard bench for ifft_butterfly_16_1: stimulus pushes hand-computed
// results, a negedge monitor pops and compares whenever an output is consumed.
module tb_ifft_butterfly_16_1;

  logic clk = 1'b0;
  logic rst_n;

  logic               in_valid, in_ready, out_valid, out_ready, ovf, ovf_clr;
  logic signed [15:0] ar, ai, br, bi, wr, wi, x1r, x1i, x2r, x2i;

  logic               s0_in_valid, s0_in_ready, s0_out_valid, s0_out_ready, s0_ovf, s0_ovf_clr;
  logic signed [15:0] s0_ar, s0_ai, s0_br, s0_bi, s0_wr, s0_wi;
  logic signed [15:0] s0_x1r, s0_x1i, s0_x2r, s0_x2i;

  int tests_run    = 0;
  int tests_failed = 0;
  int cyc          = 0;
  bit saw_block    = 0;

  typedef struct {
    logic signed [15:0] x1r, x1i, x2r, x2i;
    logic               ovf;
    bit                 chk_lat;
    int                 cyc;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  ifft_butterfly_16_1 #(.DATA_W(16), .TW_W(16), .SCALE(1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .ar(ar), .ai(ai), .br(br), .bi(bi), .wr(wr), .wi(wi),
    .out_valid(out_valid), .out_ready(out_ready),
    .x1r(x1r), .x1i(x1i), .x2r(x2r), .x2i(x2i),
    .ovf(ovf), .ovf_clr(ovf_clr)
  );

  ifft_butterfly_16_1 #(.DATA_W(16), .TW_W(16), .SCALE(0)) dut_s0 (
    .clk(clk), .rst_n(rst_n), .in_valid(s0_in_valid), .in_ready(s0_in_ready),
    .ar(s0_ar), .ai(s0_ai), .br(s0_br), .bi(s0_bi), .wr(s0_wr), .wi(s0_wi),
    .out_valid(s0_out_valid), .out_ready(s0_out_ready),
    .x1r(s0_x1r), .x1i(s0_x1i), .x2r(s0_x2r), .x2i(s0_x2i),
    .ovf(s0_ovf), .ovf_clr(s0_ovf_clr)
  );

  task automatic checkOutput(input string name, input longint actual, input longint expected);
    tests_run++;
    if (actual != expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Called at posedge+1; holds the pair until accepted, then queues the expected result.
  task automatic applyStimulus(input logic signed [15:0] a_r, a_i, b_r, b_i, w_r, w_i,
                               input logic signed [15:0] e1r, e1i, e2r, e2i,
                               input logic e_ovf, input bit lat);
    exp_t e;
    int   n;
    ar = a_r; ai = a_i; br = b_r; bi = b_i; wr = w_r; wi = w_i;
    in_valid = 1'b1;
    n = 0;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      n++;
      @(negedge clk);
    end
    if (!in_ready) begin
      checkOutput("accept_timeout", 0, 1);
    end else begin
      e.x1r = e1r; e.x1i = e1i; e.x2r = e2r; e.x2i = e2i;
      e.ovf = e_ovf; e.chk_lat = lat; e.cyc = cyc;
      sb.push_back(e);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while (sb.size() != 0 && n < budget) begin
      n++;
      @(negedge clk);
    end
    checkOutput("drain_left", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // Monitor: handshake relation, stall stability and scoreboard comparison.
  logic signed [15:0] h_x1r, h_x1i, h_x2r, h_x2i;
  bit                 was_stalled = 0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      was_stalled = 0;
    end else begin
      checkOutput("in_ready", in_ready, (!out_valid || out_ready) ? 1 : 0);
      if (out_valid && !out_ready && !in_ready) saw_block = 1;
      if (was_stalled) begin
        checkOutput("stall_valid", out_valid, 1);
        checkOutput("stall_x1r", x1r, h_x1r);
        checkOutput("stall_x1i", x1i, h_x1i);
        checkOutput("stall_x2r", x2r, h_x2r);
        checkOutput("stall_x2i", x2i, h_x2i);
      end
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checkOutput("unexpected_output", 1, 0);
        end else begin
          e = sb.pop_front();
          checkOutput("x1r", x1r, e.x1r);
          checkOutput("x1i", x1i, e.x1i);
          checkOutput("x2r", x2r, e.x2r);
          checkOutput("x2i", x2i, e.x2i);
          checkOutput("ovf", ovf, e.ovf);
          if (e.chk_lat) checkOutput("latency", cyc - e.cyc, 3);
        end
      end
      was_stalled = out_valid && !out_ready;
      h_x1r = x1r; h_x1i = x1i; h_x2r = x2r; h_x2i = x2i;
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    rst_n = 1'b0;
    in_valid = 0; out_ready = 1; ovf_clr = 0;
    ar = 0; ai = 0; br = 0; bi = 0; wr = 0; wi = 0;
    s0_in_valid = 0; s0_out_ready = 1; s0_ovf_clr = 0;
    s0_ar = 0; s0_ai = 0; s0_br = 0; s0_bi = 0; s0_wr = 0; s0_wi = 0;

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_x1r", x1r, 0);
    checkOutput("rst_x2i", x2i, 0);
    checkOutput("rst_ovf", ovf, 0);
    checkOutput("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Tests 1-3: single pairs with latency check
    applyStimulus(1000, 200, 600, -100, 32767, 0, 800, 50, 200, 150, 0, 1);
    waitDrain(20);
    applyStimulus(1000, 200, 600, -100, 0, -32768, 800, 50, -150, 200, 0, 1);
    waitDrain(20);
    applyStimulus(-3, 0, 0, 0, 32767, 0, -1, 0, -1, 0, 0, 1);
    waitDrain(20);

    // Test 4: six back-to-back pairs with a 5-cycle downstream stall
    fork
      begin
        applyStimulus(100, 50, 20, 10, 32767, 0, 60, 30, 40, 20, 0, 0);
        applyStimulus(-200, 300, 100, -100, 0, 32767, -50, 100, 200, 150, 0, 0);
        applyStimulus(7, -9, 5, -1, 32767, 0, 6, -5, 1, -4, 0, 0);
        applyStimulus(-1000, -2000, -1000, 2000, 0, -32768, -1000, 0, 2000, 0, 0, 0);
        applyStimulus(1, 1, 0, 0, 32767, 0, 1, 1, 0, 0, 0, 0);
        applyStimulus(12345, -12345, 345, -345, 32767, 0, 6345, -6345, 6000, -6000, 0, 0);
      end
      begin
        repeat (2) @(posedge clk);
        #1 out_ready = 1'b0;
        repeat (5) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    waitDrain(40);
    checkOutput("stall_blocked_input", saw_block, 1);

    // Test 5: SCALE=0 instance, saturation, sticky ovf, clear, clear-vs-set
    s0_ar = 32767; s0_ai = 0; s0_br = 32767; s0_bi = 0; s0_wr = 32767; s0_wi = 0;
    s0_in_valid = 1'b1;
    @(posedge clk);
    #1 s0_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s0_out_valid && n < 10) begin n++; @(negedge clk); end
    checkOutput("s0_valid", s0_out_valid, 1);
    checkOutput("s0_x1r", s0_x1r, 32767);
    checkOutput("s0_x1i", s0_x1i, 0);
    checkOutput("s0_x2r", s0_x2r, 0);
    checkOutput("s0_x2i", s0_x2i, 0);
    checkOutput("s0_ovf_set", s0_ovf, 1);
    repeat (3) @(negedge clk);
    checkOutput("s0_ovf_sticky", s0_ovf, 1);
    @(posedge clk);
    #1 s0_ovf_clr = 1'b1;
    @(posedge clk);
    #1 s0_ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("s0_ovf_cleared", s0_ovf, 0);
    @(posedge clk);
    #1 s0_ovf_clr = 1'b1;
    s0_in_valid = 1'b1;
    @(posedge clk);
    #1 s0_in_valid = 1'b0;
    n = 0;
    @(negedge clk);
    while (!s0_out_valid && n < 10) begin n++; @(negedge clk); end
    checkOutput("s0_clr_x1r", s0_x1r, 32767);
    checkOutput("s0_clr_wins", s0_ovf, 0);
    @(posedge clk);
    #1 s0_ovf_clr = 1'b0;
    @(negedge clk);
    checkOutput("s0_clr_after", s0_ovf, 0);
    @(posedge clk);
    #1;

    // Test 6: saturating pair sets ovf, then async reset with 3 pairs in flight
    applyStimulus(32767, 32767, -32768, -32768, 32767, 32767, 0, 0, 32767, 0, 1, 0);
    waitDrain(20);
    checkOutput("ovf_held", ovf, 1);
    applyStimulus(1000, 200, 600, -100, 32767, 0, 800, 50, 200, 150, 1, 0);
    applyStimulus(100, 50, 20, 10, 32767, 0, 60, 30, 40, 20, 1, 0);
    applyStimulus(1, 1, 0, 0, 32767, 0, 1, 1, 0, 0, 1, 0);
    #2 rst_n = 1'b0;
    sb.delete();
    #1;
    checkOutput("arst_out_valid", out_valid, 0);
    checkOutput("arst_x1r", x1r, 0);
    checkOutput("arst_x1i", x1i, 0);
    checkOutput("arst_x2r", x2r, 0);
    checkOutput("arst_x2i", x2i, 0);
    checkOutput("arst_ovf", ovf, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    repeat (8) begin
      @(negedge clk);
      checkOutput("post_rst_idle", out_valid, 0);
    end
    @(posedge clk);
    #1;
    applyStimulus(1000, 200, 600, -100, 32767, 0, 800, 50, 200, 150, 0, 1);
    waitDrain(20);

    checkOutput("sb_empty", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
